// File: rtl/uart_pkg.sv
// Register offsets, field positions and reset values shared by the UART CSR bank.
// The address decoder lives here so every block agrees on the map.
package uart_pkg;

    localparam logic [4:0] OFS_CTRL0  = 5'h00;
    localparam logic [4:0] OFS_DATA   = 5'h04;
    localparam logic [4:0] OFS_BAUD   = 5'h08;
    localparam logic [4:0] OFS_STATUS = 5'h0C;
    localparam logic [4:0] OFS_IRQ_EN = 5'h10;

    localparam int CTRL0_W = 11;

    localparam int STAT_TX_EMPTY  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_RX_FULL   = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_FRAME_ERR = 4;
    localparam int STAT_PAR_ERR   = 5;
    localparam int STAT_TX_OVF    = 6;
    localparam int STAT_LEVEL_LSB = 8;

    // Sticky flags occupy STATUS[6:3]; index 0 of the sticky vector is STATUS[3].
    localparam int STICKY_LSB = STAT_OVERRUN;
    localparam int NUM_STICKY = 4;
    localparam int NUM_IRQ    = 7;

    localparam logic [4:0] WORD_LENGTH_RESET  = 5'd8;
    localparam int         BAUD_RESET_DEFAULT = 27;

    typedef struct packed {
        logic       rx_en;
        logic       tx_en;
        logic       parity_odd;
        logic       parity_en;
        logic       oversample_by_3;
        logic       num_stop_bits;
        logic [4:0] word_length;
    } ctrl0_t;

    localparam ctrl0_t CTRL0_RESET = '{
        rx_en:           1'b0,
        tx_en:           1'b0,
        parity_odd:      1'b0,
        parity_en:       1'b0,
        oversample_by_3: 1'b0,
        num_stop_bits:   1'b0,
        word_length:     WORD_LENGTH_RESET
    };

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL0,
        SEL_DATA,
        SEL_BAUD,
        SEL_STATUS,
        SEL_IRQ_EN
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [4:0] ofs);
        reg_sel_e sel;
        case (ofs)
            OFS_CTRL0:  sel = SEL_CTRL0;
            OFS_DATA:   sel = SEL_DATA;
            OFS_BAUD:   sel = SEL_BAUD;
            OFS_STATUS: sel = SEL_STATUS;
            OFS_IRQ_EN: sel = SEL_IRQ_EN;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead head output; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_csr_bank.sv
// UART control/status register bank: line-format controls, baud divisor, TX FIFO,
// one-entry RX holding register, sticky W1C error flags and a level interrupt.
module uart_csr_bank
    import uart_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CHAR_W     = 9,
    parameter int TX_DEPTH   = 8,
    parameter int BAUD_W     = 16,
    parameter int BAUD_RESET = BAUD_RESET_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [4:0]        word_length,
    output logic              num_stop_bits,
    output logic              oversample_by_3,
    output logic              parity_en,
    output logic              parity_odd,
    output logic              tx_en,
    output logic              rx_en,
    output logic [BAUD_W-1:0] baud_div,
    output logic [CHAR_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [CHAR_W-1:0] rx_data,
    input  logic              rx_strobe,
    input  logic              rx_frame_err,
    input  logic              rx_parity_err,
    output logic              irq
);

    localparam int LVL_W = $clog2(TX_DEPTH) + 1;

    ctrl0_t                ctrl_q, ctrl_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [NUM_IRQ-1:0]    irq_en_q, irq_en_d;
    logic [CHAR_W-1:0]     rx_hold_q, rx_hold_d;
    logic                  rx_full_q, rx_full_d;
    logic [NUM_STICKY-1:0] sticky_q, sticky_d;
    logic [NUM_STICKY-1:0] sticky_set;
    logic [NUM_STICKY-1:0] sticky_clr;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           rd_word;

    reg_sel_e              sel;
    logic                  wr_en;
    logic                  rd_en;
    logic                  data_rd;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_overflow_evt;
    logic [LVL_W-1:0]      tx_level;
    logic [15:0]           status_word;
    logic                  unused_bus_bits;

    assign sel     = decode_addr(addr[4:0]);
    assign wr_en   = cs & wen;
    assign rd_en   = cs & ~wen;
    assign data_rd = rd_en & (sel == SEL_DATA);
    assign tx_push = wr_en & (sel == SEL_DATA);
    assign tx_pop  = tx_valid & tx_ready;

    assign unused_bus_bits = ^{addr, wdata};

    uart_sync_fifo #(
        .WIDTH (CHAR_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (wdata[CHAR_W-1:0]),
        .head_o  (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    assign tx_valid        = ~tx_empty;
    assign tx_overflow_evt = tx_push & tx_full & ~tx_pop;

    // A DATA read in the strobe cycle drains the old character, so it is not an overrun.
    assign sticky_set = {
        tx_overflow_evt,
        rx_strobe & rx_parity_err,
        rx_strobe & rx_frame_err,
        rx_strobe & rx_full_q & ~data_rd
    };
    assign sticky_clr = (wr_en && sel == SEL_STATUS) ?
                        wdata[STICKY_LSB +: NUM_STICKY] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STICKY; gi++) begin : g_sticky
            assign sticky_d[gi] = sticky_set[gi] | (sticky_q[gi] & ~sticky_clr[gi]);
        end
    endgenerate

    assign status_word = {8'(tx_level), 1'b0, sticky_q, rx_full_q, tx_full, tx_empty};

    always_comb begin
        ctrl_d   = ctrl_q;
        baud_d   = baud_q;
        irq_en_d = irq_en_q;
        if (wr_en) begin
            case (sel)
                SEL_CTRL0:  ctrl_d   = ctrl0_t'(wdata[CTRL0_W-1:0]);
                SEL_BAUD:   baud_d   = wdata[BAUD_W-1:0];
                SEL_IRQ_EN: irq_en_d = wdata[NUM_IRQ-1:0];
                default:    ;
            endcase
        end
    end

    // A fresh character always wins over a read-clear of the holding register.
    always_comb begin
        rx_hold_d = rx_hold_q;
        rx_full_d = rx_full_q;
        if (rx_strobe) begin
            rx_hold_d = rx_data;
            rx_full_d = 1'b1;
        end else if (data_rd) begin
            rx_full_d = 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        case (sel)
            SEL_CTRL0:  rd_word[CTRL0_W-1:0] = ctrl_q;
            SEL_DATA:   rd_word[CHAR_W-1:0]  = rx_hold_q;
            SEL_BAUD:   rd_word[BAUD_W-1:0]  = baud_q;
            SEL_STATUS: rd_word[15:0]        = status_word;
            SEL_IRQ_EN: rd_word[NUM_IRQ-1:0] = irq_en_q;
            default:    rd_word = '0;
        endcase
        rdata_d = rd_en ? rd_word : rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= CTRL0_RESET;
            baud_q    <= BAUD_W'(BAUD_RESET);
            irq_en_q  <= '0;
            rx_hold_q <= '0;
            rx_full_q <= 1'b0;
            sticky_q  <= '0;
            rdata_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            baud_q    <= baud_d;
            irq_en_q  <= irq_en_d;
            rx_hold_q <= rx_hold_d;
            rx_full_q <= rx_full_d;
            sticky_q  <= sticky_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata           = rdata_q;
    assign word_length     = ctrl_q.word_length;
    assign num_stop_bits   = ctrl_q.num_stop_bits;
    assign oversample_by_3 = ctrl_q.oversample_by_3;
    assign parity_en       = ctrl_q.parity_en;
    assign parity_odd      = ctrl_q.parity_odd;
    assign tx_en           = ctrl_q.tx_en;
    assign rx_en           = ctrl_q.rx_en;
    assign baud_div        = baud_q;
    assign irq             = |(status_word[NUM_IRQ-1:0] & irq_en_q);

endmodule
